// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit_if
// Brief    : Request/result bundle between the pipeline and the HI/LO unit.
// Revision : 1.0
// ============================================================================
interface mul_div_unit_if #(
    parameter int W = 64
);
    logic         start;
    logic [2:0]   op;
    logic         dword;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, dword, a, b, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, dword, a, b, abort,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative multiply / restoring divide unit owning the HI/LO pair.
// Revision : 1.0
// ============================================================================
module mul_div_unit #(
    parameter int W    = 64,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rstn,
    mul_div_unit_if.slave bus
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_DWORD = CW'(W / STEP);
    localparam logic [CW-1:0] CNT_WORD  = CW'(H / STEP);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            is_div, is_dw, neg_q, neg_r, div_zero;
    logic [W-1:0]    opa, opb, rem, hi, lo;
    logic [2*W-1:0]  acc;
    logic            done;

    function automatic logic [W-1:0] trim(input logic [W-1:0] x, input logic dw);
        return dw ? x : {{H{1'b0}}, x[H-1:0]};
    endfunction

    function automatic logic [W-1:0] sext(input logic [W-1:0] x, input logic dw);
        return dw ? x : {{H{x[H-1]}}, x[H-1:0]};
    endfunction

    function automatic logic top_bit(input logic [W-1:0] x, input logic dw);
        return dw ? x[W-1] : x[H-1];
    endfunction

    // Operand capture: word ops see only the low half, signed ops work on magnitudes
    logic         arith_op, mt_op, launch, mt_write, sgn_op, sa, sb;
    logic [W-1:0] a_t, b_t, a_mag, b_mag;

    always_comb begin
        arith_op = (bus.op[2] == 1'b0);
        mt_op    = (bus.op[2:1] == 2'b10);
        launch   = (state == IDLE) && bus.start && !bus.abort && arith_op;
        mt_write = (state == IDLE) && bus.start && !bus.abort && mt_op;
        sgn_op   = ~bus.op[0];
        a_t      = trim(bus.a, bus.dword);
        b_t      = trim(bus.b, bus.dword);
        sa       = sgn_op & top_bit(bus.a, bus.dword);
        sb       = sgn_op & top_bit(bus.b, bus.dword);
        a_mag    = sa ? trim(-a_t, bus.dword) : a_t;
        b_mag    = sb ? trim(-b_t, bus.dword) : b_t;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (bus.abort) state_nxt = IDLE;
                     else if (count == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One RUN cycle resolves STEP bits, MSB first for both multiply and divide
    logic [2*W-1:0] acc_s;
    logic [W-1:0]   opa_s, rem_s;
    logic [W:0]     rem_sh, rem_diff;
    logic           qbit;

    always_comb begin
        acc_s    = acc;
        opa_s    = opa;
        rem_s    = rem;
        rem_sh   = '0;
        rem_diff = '0;
        qbit     = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (is_div) begin
                rem_sh   = {rem_s, top_bit(opa_s, is_dw)};
                rem_diff = rem_sh - {1'b0, opb};
                qbit     = (rem_sh >= {1'b0, opb});
                rem_s    = qbit ? rem_diff[W-1:0] : rem_sh[W-1:0];
                opa_s    = {opa_s[W-2:0], qbit};
            end else begin
                acc_s = {acc_s[2*W-2:0], 1'b0}
                      + (top_bit(opa_s, is_dw) ? {{W{1'b0}}, opb} : {2*W{1'b0}});
                opa_s = {opa_s[W-2:0], 1'b0};
            end
        end
    end

    // Sign correction; a zero divisor leaves the dividend in rem and forces all-ones quotient
    logic [2*W-1:0] prod;
    logic [W-1:0]   q_t, r_t, q_v, r_v, hi_f, lo_f;

    always_comb begin
        prod = neg_q ? -acc : acc;
        q_t  = trim(opa, is_dw);
        r_t  = trim(rem, is_dw);
        q_v  = neg_q ? trim(-q_t, is_dw) : q_t;
        r_v  = neg_r ? trim(-r_t, is_dw) : r_t;
        if (is_div) begin
            lo_f = div_zero ? {W{1'b1}} : sext(q_v, is_dw);
            hi_f = sext(r_v, is_dw);
        end else begin
            lo_f = sext(prod[W-1:0], is_dw);
            hi_f = is_dw ? prod[2*W-1:W] : sext({{H{1'b0}}, prod[W-1:H]}, 1'b0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            is_div   <= 1'b0;
            is_dw    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            rem      <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                count    <= bus.dword ? CNT_DWORD : CNT_WORD;
                is_div   <= bus.op[1];
                is_dw    <= bus.dword;
                neg_q    <= sa ^ sb;
                neg_r    <= sa;
                div_zero <= (b_t == '0);
                opa      <= a_mag;
                opb      <= b_mag;
                rem      <= '0;
                acc      <= '0;
            end else if (state == RUN) begin
                acc   <= acc_s;
                opa   <= opa_s;
                rem   <= rem_s;
                count <= bus.abort ? '0 : count - CW'(1);
            end
            if (state == FIX) begin
                count <= '0;
                if (!bus.abort) begin
                    hi   <= hi_f;
                    lo   <= lo_f;
                    done <= 1'b1;
                end
            end
            if (mt_write) begin
                if (bus.op[0]) lo <= bus.a;
                else           hi <= bus.a;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule
`default_nettype wire
